// File: rtl/game_timer.sv
// game_timer: play-time prescaler/counter feeding the level sequencer, plus a
// synchronized and debounced menu button that yields a one-cycle userSel pulse.
// Optional build macro GAME_TIMER_PAUSE_EN adds a 'pause' input that freezes
// the timer while playing; without it the timer behaves as if pause were 0.
module game_timer #(
  parameter int CLK_DIV      = 1250000,
  parameter int TIME_W       = 11,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  input  logic              run,
  input  logic              playerDied,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic              pause,
`endif
  output logic [TIME_W-1:0] game_time,
  output logic              slowClk,
  output logic              userSel
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);

  logic [PW-1:0] presc;
  logic          btn_sync_p0;
  logic          btn_sync_p1;
  logic [DW-1:0] db_cnt;
  logic          btn_db;
  logic          btn_db_d;
  logic          pause_hold;

`ifdef GAME_TIMER_PAUSE_EN
  assign pause_hold = pause;
`else
  assign pause_hold = 1'b0;
`endif

  // Saturating increment: the play time sticks at all-ones instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    if (v == {TIME_W{1'b1}})
      return v;
    else
      return v + TIME_W'(1);
  endfunction

  // Timer: clear outranks pause, pause outranks counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      game_time <= '0;
      slowClk   <= 1'b0;
    end else if (playerDied || !run) begin
      presc     <= '0;
      game_time <= '0;
      slowClk   <= 1'b0;
    end else if (pause_hold) begin
      slowClk   <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc     <= '0;
      game_time <= sat_inc(game_time);
      slowClk   <= 1'b1;
    end else begin
      presc     <= presc + PW'(1);
      slowClk   <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
    end else begin
      btn_sync_p0 <= btn_raw;
      btn_sync_p1 <= btn_sync_p0;
    end
  end

  // Debounce: accept a new level only after it differs for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_sync_p1 != btn_db) begin
      if (db_cnt == DB_MAX) begin
        btn_db <= btn_sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Rising-edge detect on the debounced level, registered into a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db_d <= 1'b0;
      userSel  <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      userSel  <= btn_db & ~btn_db_d;
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: scoreboard bench for game_timer (CLK_DIV=4, DEBOUNCE_CYC=3).
module tb_game_timer;

  localparam int CLK_DIV      = 4;
  localparam int TIME_W       = 11;
  localparam int DEBOUNCE_CYC = 3;
  localparam int TIME_MAX     = (1 << TIME_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              btn_raw = 1'b0;
  logic              run = 1'b0;
  logic              playerDied = 1'b0;
  logic              pause = 1'b0;
  logic [TIME_W-1:0] game_time;
  logic              slowClk;
  logic              userSel;

  game_timer #(.CLK_DIV(CLK_DIV), .TIME_W(TIME_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .run        (run),
    .playerDied (playerDied),
`ifdef GAME_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .game_time  (game_time),
    .slowClk    (slowClk),
    .userSel    (userSel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int s;
    int u;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_slow   = 0;
  int n_sel    = 0;
  int sel_at   = 0;

  // reference model state
  int run_cyc  = 0;
  int m_s1     = 0;
  int m_s2     = 0;
  int m_run    = 0;
  int m_db     = 0;
  int m_db_old = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Predict outputs after the coming edge from the inputs currently applied.
  task automatic predict(output exp_t e);
    int paused;
    if (!reset) begin
      run_cyc = 0; m_s1 = 0; m_s2 = 0; m_run = 0; m_db = 0; m_db_old = 0;
      e.t = 0; e.s = 0; e.u = 0;
      return;
    end
    paused = pause;
`ifndef GAME_TIMER_PAUSE_EN
    paused = 0;
`endif
    if (playerDied || !run) begin
      run_cyc = 0;
      e.s = 0;
    end else if (paused != 0) begin
      e.s = 0;
    end else begin
      run_cyc++;
      e.s = (run_cyc % CLK_DIV == 0) ? 1 : 0;
    end
    e.t = (run_cyc / CLK_DIV > TIME_MAX) ? TIME_MAX : run_cyc / CLK_DIV;
    e.u = (m_db == 1 && m_db_old == 0) ? 1 : 0;
    m_db_old = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DEBOUNCE_CYC) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(btn_raw);
  endtask

  // One clock: push the prediction, let the edge happen, pop and compare.
  task automatic step(input int n);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      predict(e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("game_time", int'(game_time), got.t);
      check("slowClk", int'(slowClk), got.s);
      check("userSel", int'(userSel), got.u);
      if (slowClk) n_slow++;
      if (userSel) n_sel++;
    end
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 400 && int'(game_time) != target; i++) step(1);
    check("reach_time", int'(game_time), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    step(3);
    check("rst_time", int'(game_time), 0);
    check("rst_slow", int'(slowClk), 0);
    check("rst_sel", int'(userSel), 0);
    reset = 1'b1;

    // 40 cycles of play: 10 ticks, each on a 4-cycle boundary
    run = 1'b1;
    n_slow = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (slowClk) check("slow_pos", i % CLK_DIV, 0);
    end
    check("time_40", int'(game_time), 10);
    check("slow_cnt_40", n_slow, 10);

    // playerDied clear at game_time=5, then restart timing
    playerDied = 1'b1; step(1); playerDied = 1'b0;
    run_until(5);
    playerDied = 1'b1; step(1); playerDied = 1'b0;
    check("died_clear", int'(game_time), 0);
    step(3);
    check("died_wait3", int'(game_time), 0);
    step(1);
    check("died_first_inc", int'(game_time), 1);
    check("died_first_slow", int'(slowClk), 1);

    // playerDied landing on a tick edge
    step(CLK_DIV - 1);
    playerDied = 1'b1; step(1); playerDied = 1'b0;
    check("tick_clear_slow", int'(slowClk), 0);
    check("tick_clear_time", int'(game_time), 0);

    // saturation
    step(8188);
    check("sat_reach", int'(game_time), TIME_MAX);
    n_slow = 0;
    step(20);
    check("sat_hold", int'(game_time), TIME_MAX);
    check("sat_slow_cnt", n_slow, 5);

    // run dropped at game_time=7
    playerDied = 1'b1; step(1); playerDied = 1'b0;
    run_until(7);
    run = 1'b0; step(1);
    check("run_drop", int'(game_time), 0);

    // held button: one pulse at 6 cycles
    n_sel = 0; sel_at = 0;
    btn_raw = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (userSel && sel_at == 0) sel_at = i;
    end
    check("press_cnt", n_sel, 1);
    check("press_lat", sel_at, 6);
    n_sel = 0;
    btn_raw = 1'b0; step(30);
    check("release_cnt", n_sel, 0);
    btn_raw = 1'b1; step(2); btn_raw = 1'b0; step(20);
    check("glitch_cnt", n_sel, 0);

    // reset mid-count and mid-debounce
    run = 1'b1; step(10);
    btn_raw = 1'b1; step(2);
    reset = 1'b0;
    #1;
    check("async_rst_time", int'(game_time), 0);
    check("async_rst_slow", int'(slowClk), 0);
    check("async_rst_sel", int'(userSel), 0);
    btn_raw = 1'b0;
    step(3);
    reset = 1'b1;
    n_sel = 0;
    step(20);
    check("post_rst_sel", n_sel, 0);
    check("post_rst_time", int'(game_time), 5);

`ifdef GAME_TIMER_PAUSE_EN
    // pause at game_time=3
    playerDied = 1'b1; step(1); playerDied = 1'b0;
    run_until(3);
    pause = 1'b1; n_slow = 0;
    step(20);
    check("pause_hold", int'(game_time), 3);
    check("pause_slow", n_slow, 0);
    pause = 1'b0;
    step(CLK_DIV - 1);
    check("pause_resume_wait", int'(game_time), 3);
    step(1);
    check("pause_resume_inc", int'(game_time), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Upstream feeder of the level sequencer.
- Produces the `game_time` count that drives level/obstacle progression, the `slowClk` tick pulse, and a clean one-cycle `userSel` pulse from the raw menu push-button.
- Clears the timer whenever the sequencer is not in a playing state or the player dies, so every level attempt starts from `game_time` = 0.

Parameters:
- CLK_DIV, 1250000: clk cycles per `game_time` increment; legal range ≥ 2.
- TIME_W, 11: width of `game_time`.
- DEBOUNCE_CYC, 500000: consecutive stable cycles required to accept a button level change; legal range ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_raw  in  1  raw asynchronous push-button, active-high
- run  in  1  high while the sequencer is in a playing state (not menu/win screens)
- playerDied  in  1  level-sensitive clear request from collision logic
- game_time  out  TIME_W  elapsed play time in ticks
- slowClk  out  1  one-clk pulse coincident with each `game_time` increment
- userSel  out  1  one-clk pulse per accepted button press

Behaviour:
- Reset (reset=0, async): prescaler, `game_time`, `slowClk`, `userSel`, synchronizer flops, debounce counter and debounced level all go to 0.
- Button path:
  - 2-FF synchronizer on `btn_raw` produces `btn_sync`.
  - The debounce counter increments each cycle `btn_sync` differs from the debounced level `btn_db`. It clears to 0 in any cycle they are equal.
  - When the counter equals DEBOUNCE_CYC-1 and the inputs still differ: `btn_db` takes `btn_sync` at the next edge and the counter clears.
  - `userSel` is a registered pulse: high for exactly one cycle, the cycle after `btn_db` rises. A falling `btn_db` produces no pulse.
  - A held button yields exactly one pulse. Glitches shorter than DEBOUNCE_CYC cycles yield none.
  - The button path runs regardless of `run` and `playerDied`.
- Timer, evaluated per edge in priority order:
  1. `playerDied`=1 or `run`=0: prescaler←0, `game_time`←0, `slowClk`←0.
  2. Prescaler == CLK_DIV-1: prescaler←0; `game_time`←`game_time`+1, saturating at 2^TIME_W-1; `slowClk`←1.
  3. Otherwise: prescaler←prescaler+1, `slowClk`←0.
- Saturation: at all-ones, `game_time` holds. `slowClk` still pulses every CLK_DIV cycles.
- `game_time` and `slowClk` change on the same edge. Consumers comparing `game_time` see the new value in the `slowClk`=1 cycle.
- `run` rising: the first increment occurs exactly CLK_DIV cycles after the first edge with `run`=1.
- Simultaneous `playerDied` and a tick: the clear wins; no pulse is issued.
- Reset asserted mid-count or mid-debounce: all state clears immediately. Button presses in progress are discarded and no `userSel` is issued.
- The prescaler is ceil(log2(CLK_DIV)) bits. The debounce counter is ceil(log2(DEBOUNCE_CYC+1)) bits.

Optional Feature:
- GAME_TIMER_PAUSE_EN
- Defined: adds input port `pause` (1 bit).
  - While `run`=1, `playerDied`=0 and `pause`=1, the prescaler and `game_time` hold and `slowClk`=0.
  - Releasing `pause` resumes counting from the held prescaler value.
  - The clear conditions keep priority over `pause`.
  - The button path is unaffected.
- Undefined: no `pause` port; behaviour is identical to `pause` tied 0.

Test Plan (CLK_DIV=4, DEBOUNCE_CYC=3, TIME_W=11):
- Reset release, `run`=1 for 40 cycles:
  - `game_time` reaches 10.
  - `slowClk` pulses exactly 10 times, each 1 cycle wide, 4 cycles apart, coincident with each increment.
- `run`=1 until `game_time`=5, then `playerDied`=1 for 1 cycle → `game_time`=0 next edge; the next increment comes 4 cycles after `playerDied` deasserts. Repeat with `playerDied` landing on a tick edge → no `slowClk` pulse, `game_time`=0.
- Force `game_time` toward 2047 (run 8188 cycles) and continue 20 cycles → holds 2047, `slowClk` keeps pulsing every 4 cycles.
- `btn_raw` high for 30 cycles → exactly one `userSel` pulse, 1 cycle wide, within 6 cycles of the rising edge. Release → no pulse. `btn_raw` 2-cycle glitch → no pulse.
- `run` dropped to 0 at `game_time`=7 → 0 next edge. Assert reset mid-debounce (`btn_raw` high 2 cycles) → all outputs 0, no `userSel` after reset release while the button stays low.
- With GAME_TIMER_PAUSE_EN: `pause`=1 at `game_time`=3 for 20 cycles → stays 3, no `slowClk`. Release → increments to 4 after the remaining prescaler count.
